dual_flop_bank: RTL and testbench

- Parameterised bank of storage primitives for reset-control and synchroniser chains.
- Provides two parallel W-bit lanes:
  - a plain D flip-flop lane (dff behaviour);
  - a D flip-flop lane with a per-bit asynchronous active-high set (dff_async_set behaviour).
- Reset-controller logic chains these lanes to turn async glitches/levels into multi-cycle synchronous pulses.

---
 rtl/dual_flop_bank_pkg.sv | 13 +
 rtl/dual_flop_bank_async_set_flop_bit.sv | 42 ++++
 rtl/dual_flop_bank.sv | 72 +++++++
 tb/tb_dual_flop_bank.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dual_flop_bank_pkg.sv
// Shared constants and types for the dual_flop_bank storage bank.
package dual_flop_bank_pkg;

    localparam int DFB_MAX_WIDTH     = 64;
    localparam int DFB_DEFAULT_WIDTH = 1;

    // Widest lane vector; instances slice this down to their own WIDTH.
    typedef logic [DFB_MAX_WIDTH-1:0] dfb_lane_max_t;

    localparam dfb_lane_max_t DFB_DEFAULT_PLAIN_RST_VAL = '0;
    localparam dfb_lane_max_t DFB_DEFAULT_AS_RST_VAL    = '0;

endpackage

// File: rtl/dual_flop_bank_async_set_flop_bit.sv
// Single-bit flop with a true asynchronous active-high set, synchronous
// active-high reset and a clock enable. The set overrides everything,
// including a coincident clock edge; once set, the bit stays 1 until the
// first rising clock edge that sees the set low.
module async_set_flop_bit
    import dual_flop_bank_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic set,
    input  logic d,
    output logic q
);

    logic q_d;
    logic q_q;

    // Next value: reset wins over enable; a disabled edge holds.
    always_comb begin
        q_d = q_q;
        if (reset) begin
            q_d = RST_VAL;
        end else if (en) begin
            q_d = d;
        end
    end

    // Storage with asynchronous set; a glitch on set is captured immediately.
    always_ff @(posedge clk or posedge set) begin
        if (set) begin
            q_q <= 1'b1;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/dual_flop_bank.sv
// Parameterised bank of two W-bit flop lanes used to build reset-control
// and synchroniser chains:
//   - plain lane:     q    <= reset ? PLAIN_RST_VAL : d
//   - async-set lane: as_q  forced to 1 by as_set[i] asynchronously, else
//                     as_q <= reset ? AS_RST_VAL : as_d
// Optional clock enable: define DUAL_FLOP_BANK_CLK_ENABLE_EN to add input
// 'en'; with en low and reset low both lanes hold. Without the macro the
// lanes load on every edge, exactly as if en were tied high.
module dual_flop_bank
    import dual_flop_bank_pkg::*;
#(
    parameter int               WIDTH         = DFB_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] PLAIN_RST_VAL = DFB_DEFAULT_PLAIN_RST_VAL[WIDTH-1:0],
    parameter logic [WIDTH-1:0] AS_RST_VAL    = DFB_DEFAULT_AS_RST_VAL[WIDTH-1:0]
) (
    input  logic             clk,
    input  logic             reset,
`ifdef DUAL_FLOP_BANK_CLK_ENABLE_EN
    input  logic             en,
`endif
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] as_d,
    input  logic [WIDTH-1:0] as_set,
    output logic [WIDTH-1:0] as_q
);

    typedef logic [WIDTH-1:0] lane_t;

    logic  en_int;
    lane_t plain_d;
    lane_t plain_q;

`ifdef DUAL_FLOP_BANK_CLK_ENABLE_EN
    assign en_int = en;
`else
    assign en_int = 1'b1;
`endif

    // Plain lane next value: reset load, enabled load, otherwise hold.
    always_comb begin
        plain_d = plain_q;
        if (reset) begin
            plain_d = PLAIN_RST_VAL;
        end else if (en_int) begin
            plain_d = d;
        end
    end

    // Plain lane storage; purely clocked, no path from d to q.
    always_ff @(posedge clk) begin
        plain_q <= plain_d;
    end

    assign q = plain_q;

    // Async-set lane: one independent flop per bit so each set is its own
    // asynchronous domain with no cross-bit interaction.
    for (genvar i = 0; i < WIDTH; i++) begin : g_as_bit
        async_set_flop_bit #(
            .RST_VAL (AS_RST_VAL[i])
        ) u_bit (
            .clk   (clk),
            .reset (reset),
            .en    (en_int),
            .set   (as_set[i]),
            .d     (as_d[i]),
            .q     (as_q[i])
        );
    end

endmodule

// File: tb/tb_dual_flop_bank.sv
// Self-checking bench for dual_flop_bank (WIDTH=4, zero reset values).
// The reference model tracks the register contents of each lane at a
// behavioural level: the async-set lane output is "stored value OR current
// set", and any set seen between edges latches a 1 into the stored value.
`timescale 1ns/1ps
module tb_dual_flop_bank;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic [W-1:0] as_d;
    logic [W-1:0] as_set;
    logic [W-1:0] as_q;
`ifdef DUAL_FLOP_BANK_CLK_ENABLE_EN
    logic         en;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [W-1:0] m_q;
    logic [W-1:0] m_as;
    logic [W-1:0] hold;

    always #5 clk = ~clk;

    dual_flop_bank #(
        .WIDTH         (W),
        .PLAIN_RST_VAL (4'h0),
        .AS_RST_VAL    (4'h0)
    ) dut (
        .clk    (clk),
        .reset  (reset),
`ifdef DUAL_FLOP_BANK_CLK_ENABLE_EN
        .en     (en),
`endif
        .d      (d),
        .q      (q),
        .as_d   (as_d),
        .as_set (as_set),
        .as_q   (as_q)
    );

    function automatic logic en_now();
`ifdef DUAL_FLOP_BANK_CLK_ENABLE_EN
        return en;
`else
        return 1'b1;
`endif
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_both(input string tag);
        check({tag, "_q"}, q, m_q);
        check({tag, "_as_q"}, as_q, m_as | as_set);
    endtask

    // One clock edge; the model applies the edge rules with the inputs
    // present at the edge, then outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        if (reset)         m_q = 4'h0;
        else if (en_now()) m_q = d;
        if (reset)         m_as = as_set | 4'h0;
        else if (en_now()) m_as = as_set | as_d;
        else               m_as = as_set | m_as;
        #1;
    endtask

    // Sub-cycle set pulse on 'bits' on top of any held set bits.
    task automatic pulse(input logic [W-1:0] bits, input string tag);
        as_set = hold | bits;
        m_as   = m_as | bits;
        #1;
        check({tag, "_during"}, as_q, m_as | as_set);
        as_set = hold;
        #1;
        check({tag, "_after"}, as_q, m_as | as_set);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        hold   = '0;
        reset  = 1'b1;
        d      = 4'hF;
        as_d   = 4'hF;
        as_set = 4'h0;
`ifdef DUAL_FLOP_BANK_CLK_ENABLE_EN
        en     = 1'b1;
`endif
        #2;

        // Reset load
        tick();
        check("rst_q", q, 4'h0);
        check("rst_as_q", as_q, 4'h0);
        check_both("rst_model");

        // Release reset: data loads on next edge
        reset = 1'b0;
        tick();
        check("rel_q", q, 4'hF);
        check("rel_as_q", as_q, 4'hF);

        // Plain latency and stability between edges
        d = 4'hA; tick(); check("lat_a", q, 4'hA);
        d = 4'h5; #3; check("hold_between", q, 4'hA);
        tick(); check("lat_5", q, 4'h5);
        d = 4'h3; tick(); check("lat_3", q, 4'h3);

        // Sub-cycle set glitch on bit 2
        as_d = 4'h0;
        tick();
        check("glitch_pre", as_q, 4'h0);
        #1;
        pulse(4'h4, "glitch2");
        check("glitch_only_bit2", as_q, 4'h4);
        tick();
        check("glitch_cleared", as_q, 4'h0);

        // Set priority over reset and as_d
        reset  = 1'b1;
        as_d   = 4'h0;
        hold   = 4'h1;
        as_set = hold;
        m_as   = m_as | hold;
        #1;
        check("prio_imm", as_q, 4'h1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("prio_edge", as_q, 4'h1);
            check("prio_q_rst", q, 4'h0);
        end
        hold   = 4'h0;
        as_set = 4'h0;
        #1;
        check("prio_drop_hold", as_q, 4'h1);
        tick();
        check("prio_released", as_q, 4'h0);
        reset = 1'b0;
        tick();

        // Two-stage chain: as_q[0] drives as_d[1] externally
        as_d = {2'b00, m_as[0], 1'b0};
        tick();
        #1;
        pulse(4'h3, "chain");
        as_d = {2'b00, m_as[0], 1'b0};
        tick();
        check("chain_e1", as_q, 4'h2);
        check_both("chain_e1_model");
        as_d = {2'b00, m_as[0], 1'b0};
        tick();
        check("chain_e2", as_q, 4'h0);

`ifdef DUAL_FLOP_BANK_CLK_ENABLE_EN
        // Clock enable
        d = 4'h3; as_d = 4'h6; tick();
        en = 1'b0; d = 4'h9; as_d = 4'h1; tick();
        check("en_hold_q", q, 4'h3);
        check("en_hold_as_q", as_q, 4'h6);
        reset = 1'b1; tick();
        check("en_rst_q", q, 4'h0);
        check("en_rst_as_q", as_q, 4'h0);
        reset = 1'b0;
        hold = 4'h8; as_set = hold; m_as = m_as | hold;
        #1;
        check("en_set_imm", as_q, 4'h8);
        tick();
        check("en_set_edge", as_q, 4'h8);
        hold = 4'h0; as_set = 4'h0;
        en = 1'b1; as_d = 4'h0;
        tick();
        check("en_set_released", as_q, 4'h0);
`endif

        // Randomised operation against the model
        for (int it = 0; it < 80; it++) begin
            d     = 4'($urandom_range(0, 15));
            as_d  = 4'($urandom_range(0, 15));
            reset = ($urandom_range(0, 7) == 0);
`ifdef DUAL_FLOP_BANK_CLK_ENABLE_EN
            en    = ($urandom_range(0, 3) != 0);
`endif
            hold   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            as_set = hold;
            m_as   = m_as | hold;
            #1;
            check_both("rnd_mid");
            if ($urandom_range(0, 2) == 0) begin
                pulse(4'($urandom_range(1, 15)), "rnd_pulse");
            end
            if ($urandom_range(0, 1) == 0) begin
                hold   = 4'h0;
                as_set = 4'h0;
                #1;
                check_both("rnd_drop");
            end
            tick();
            check_both("rnd_edge");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
